alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I ALU control block.
- Adds a registered valid/ready handshake and keeps the base integer operations (1-cycle latency).
- Adds iterative RV M-extension multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
- Sits between decode/operand-fetch and writeback in the execute stage; a kill input lets the pipeline squash an in-flight operation.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- T, 0.000, propagation delay passed to structural sub-units (add, shift, slt).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- alu_op  input  5  operation code (see Behaviour)
- a  input  XLEN  operand 1
- b  input  XLEN  operand 2
- kill  input  1  abort in-flight operation
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  operation result
- busy  output  1  high while in MUL or DIV state

Behaviour:
- Reset: asynchronous, active-high. Forces state=IDLE, out_valid=0, result=0, busy=0, internal accumulators=0. in_ready=0 while rst is high, then 1 in IDLE.
- Opcodes:
  - 00000 add, 00001 sub, 00010 xor, 00011 or, 00100 and, 00101 sll, 00110 srl, 00111 sra, 01000 slt, 01001 sltu.
  - 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu.
  - All other codes: result=0, 1-cycle latency.
- Shifts use b[log2(XLEN)-1:0]. All arithmetic is modulo 2^XLEN.
- Handshake:
  - A request is accepted on a clock edge with in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue on a result handshake.
  - Once out_valid rises, result stays stable until out_valid && out_ready.
  - Operands are captured at acceptance; later changes on a/b/alu_op are ignored.
- State machine:
  - IDLE -> DONE on accepting a base op. The result is registered, so out_valid is seen the cycle after acceptance.
  - IDLE -> MUL on accepting mul*. Operand magnitudes are computed per signedness. The block iterates XLEN cycles over a 2*XLEN product, fixes the sign, then goes to DONE.
    - Latency: out_valid asserts XLEN+2 cycles after acceptance.
  - IDLE -> DIV on accepting div*/rem*. Restoring division over XLEN cycles on magnitudes; quotient sign = sa^sb, remainder sign = sa; then DONE.
    - Latency: XLEN+2 cycles.
  - DONE -> IDLE on out_ready with no new request. DONE -> DONE/MUL/DIV on out_ready with a new accepted request.
- Divide special cases (resolved in 1 cycle, IDLE -> DONE):
  - Divide by zero: quotient = all ones, remainder = a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a, remainder = 0.
- kill:
  - Synchronous. In any state: next state IDLE, out_valid=0, busy=0; any result is discarded.
  - kill has priority over a simultaneous acceptance; that request is dropped.
- busy=1 exactly while state is MUL or DIV.
- Asynchronous reset mid-operation abandons the operation immediately; no result is produced.

Optional Feature:
- Macro: ALU_ITER_MDU_EN.
- Defined: the MUL/DIV states and datapath are built as above.
- Undefined:
  - Opcodes 1xxxx behave as unsupported: result=0, 1-cycle latency.
  - busy is tied 0; MUL/DIV logic is absent.

Test Plan:
- Reset, then add a=0x00000005 b=0x00000003 with out_ready=1 -> out_valid one cycle after acceptance, result=0x00000008; sub same operands -> 0x00000002.
- sra a=0x80000000 b=0x00000004 -> 0xF8000000; sltu a=0x00000001 b=0xFFFFFFFF -> 0x00000001; alu_op=01111 -> 0x00000000.
- mulh a=0xFFFFFFFF b=0xFFFFFFFF -> result 0x00000000 after 34 cycles, busy high for 32 cycles; mulhu same operands -> 0xFFFFFFFE; mul 0x00010000*0x00010000 -> 0x00000000.
- div a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu by 0 -> 0xFFFFFFFF; rem by 0 with a=0x1234 -> 0x00001234; div 0x80000000 by 0xFFFFFFFF -> 0x80000000, both special cases in 1 cycle.
- out_ready held 0 for 5 cycles after an add completes -> out_valid and result stable, in_ready=0; raise out_ready together with a new in_valid -> back-to-back acceptance.
- kill asserted 10 cycles into a divu -> next cycle state IDLE, busy=0, out_valid never asserts; async rst pulsed mid-mul -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU with a registered valid/ready handshake.
// Base RV32I/RV64I integer ops complete in one cycle. When the macro
// ALU_ITER_MDU_EN is defined, the RV M-extension ops are added as an
// iterative unit: shift-add multiply and restoring divide, one bit per
// cycle, followed by one sign-fix cycle. Without the macro, opcodes 1xxxx
// return 0 with one-cycle latency and busy is tied low.
module alu_iter #(
  parameter int  XLEN = 32,
  parameter real T    = 0.0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;

  // T only matters for delay-annotated structural variants; this RTL is
  // zero-delay, so the parameter is merely elaborated here.
  if (T < 0.0) begin : g_negative_delay_ignored
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_SIGN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              accept;

  // Single-cycle integer operations; anything not listed yields zero.
  function automatic logic [XLEN-1:0] base_alu(input logic [4:0]      op,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_XOR:  r = x ^ y;
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_SLL:  r = x << y[SHW-1:0];
      OP_SRL:  r = x >> y[SHW-1:0];
      OP_SRA:  r = $signed(x) >>> y[SHW-1:0];
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

`ifdef ALU_ITER_MDU_EN
  localparam logic [4:0]      OP_MULH   = 5'b10001;
  localparam logic [4:0]      OP_MULHSU = 5'b10010;
  localparam logic [4:0]      OP_DIV    = 5'b10100;
  localparam logic [4:0]      OP_REM    = 5'b10110;
  localparam logic [SHW-1:0]  CNT_LAST  = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  // hi/lo form the 2*XLEN product during multiply and the
  // remainder/quotient pair during divide; mcand is multiplicand or divisor.
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic              neg_q, neg_d, sel_hi_q, sel_hi_d, is_div_q, is_div_d;

  logic              is_mul_op, is_div_op, a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_rs, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel, sign_res;

  // Decode signedness of the incoming request and form operand magnitudes.
  always_comb begin
    is_mul_op = (alu_op[4:2] == 3'b100);
    is_div_op = (alu_op[4:2] == 3'b101);
    a_sgn     = 1'b0;
    b_sgn     = 1'b0;
    case (alu_op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OP_MULHSU: a_sgn = 1'b1;
      default:   a_sgn = 1'b0;
    endcase
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One shift-add / restoring-subtract step, plus the final sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_rs   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rs - {1'b0, mcand_q};
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_sel  = sel_hi_q ? hi_q : lo_q;
    if (is_div_q) begin
      sign_res = neg_q ? -div_sel : div_sel;
    end else begin
      sign_res = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
  assign busy = 1'b0;
`endif

  // Next-state, result and iterative datapath control.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_ITER_MDU_EN
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    sel_hi_d = sel_hi_q;
    is_div_d = is_div_q;
`endif
    if (kill) begin
      state_d  = S_IDLE;
      result_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_d  = S_DONE;
            result_d = base_alu(alu_op, a, b);
`ifdef ALU_ITER_MDU_EN
            if (is_mul_op) begin
              state_d  = S_MUL;
              cnt_d    = '0;
              hi_d     = '0;
              lo_d     = mag_b;
              mcand_d  = mag_a;
              neg_d    = sa ^ sb;
              sel_hi_d = (alu_op[1:0] != 2'b00);
              is_div_d = 1'b0;
            end else if (is_div_op) begin
              // Divide-by-zero and signed overflow finish without iterating.
              if (b == '0) begin
                result_d = alu_op[1] ? a : '1;
              end else if (!alu_op[0] && (a == MIN_INT) && (b == '1)) begin
                result_d = alu_op[1] ? '0 : a;
              end else begin
                state_d  = S_DIV;
                cnt_d    = '0;
                hi_d     = '0;
                lo_d     = mag_a;
                mcand_d  = mag_b;
                sel_hi_d = alu_op[1];
                neg_d    = alu_op[1] ? sa : (sa ^ sb);
                is_div_d = 1'b1;
              end
            end
`endif
          end else if ((state_q == S_DONE) && out_ready) begin
            state_d = S_IDLE;
          end
        end
`ifdef ALU_ITER_MDU_EN
        S_MUL: begin
          hi_d  = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == CNT_LAST) state_d = S_SIGN;
        end
        S_DIV: begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_rs[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == CNT_LAST) state_d = S_SIGN;
        end
        S_SIGN: begin
          result_d = sign_res;
          state_d  = S_DONE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_ITER_MDU_EN
  // Iteration counter and multiply/divide working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      sel_hi_q <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      sel_hi_q <= sel_hi_d;
      is_div_q <= is_div_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (XLEN=32). Expected results are queued when a
// request is driven and compared when the block presents its result.
// Expectations for the 1xxxx opcodes follow the ALU_ITER_MDU_EN setting.
module tb_alu_iter;

`ifdef ALU_ITER_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif
  localparam int MD_LAT  = MDU_ON ? 34 : 1;
  localparam int MD_BUSY = MDU_ON ? 32 : 0;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, XOR = 5'b00010,
                         AND = 5'b00100, SLL = 5'b00101, SRA = 5'b00111,
                         SLT = 5'b01000, SLTU = 5'b01001, BAD = 5'b01111,
                         MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010,
                         MULHU = 5'b10011, DIV = 5'b10100, DIVU = 5'b10101,
                         REM = 5'b10110, REMU = 5'b10111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] a, b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  alu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdx(input logic [31:0] v);
    return MDU_ON ? v : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Compare the presented result with the oldest queued expectation.
  task automatic pop_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected <queue empty>", tag, result);
    end else begin
      e = exp_q.pop_front();
      check(tag, result, e);
    end
  endtask

  // Issue one request (out_ready=1), scramble inputs after acceptance,
  // then measure latency and busy cycles and score the result.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    exp_q.push_back(expv);
    in_valid = 1'b1;
    alu_op   = op;
    a        = x;
    b        = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op   = 5'($urandom);
    a        = $urandom;
    b        = $urandom;
    lat  = 1;
    bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/busy_cycles"}, bcnt, exp_busy);
    pop_check({tag, "/result"});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    logic        seen;
    rst = 1'b1; in_valid = 1'b0; alu_op = '0; a = '0; b = '0;
    kill = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check1("rst/in_ready", in_ready, 1'b0);
    check1("rst/out_valid", out_valid, 1'b0);
    check1("rst/busy", busy, 1'b0);
    check("rst/result", result, 32'h0);
    rst = 1'b0;
    #1;
    check1("idle/in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Base operations.
    run_op("add", ADD, 32'h5, 32'h3, 32'h8, 1, 0);
    run_op("sub", SUB, 32'h5, 32'h3, 32'h2, 1, 0);
    run_op("sra", SRA, 32'h80000000, 32'h4, 32'hF8000000, 1, 0);
    run_op("sltu", SLTU, 32'h1, 32'hFFFFFFFF, 32'h1, 1, 0);
    run_op("slt", SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1, 0);
    run_op("bad_op", BAD, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom;
      run_op("add_rnd", ADD, x, y, x + y, 1, 0);
      run_op("and_rnd", AND, x, y, x & y, 1, 0);
      run_op("sll_rnd", SLL, x, y, x << y[4:0], 1, 0);
    end

    // Multiply.
    run_op("mulh", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, MD_LAT, MD_BUSY);
    run_op("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, mdx(32'hFFFFFFFE), MD_LAT, MD_BUSY);
    run_op("mul_wrap", MUL, 32'h00010000, 32'h00010000, 32'h0, MD_LAT, MD_BUSY);
    run_op("mul_neg", MUL, 32'h7, 32'hFFFFFFFD, mdx(32'hFFFFFFEB), MD_LAT, MD_BUSY);
    run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'h2, mdx(32'hFFFFFFFF), MD_LAT, MD_BUSY);

    // Divide, including the one-cycle special cases.
    run_op("div", DIV, 32'hFFFFFFF9, 32'h2, mdx(32'hFFFFFFFD), MD_LAT, MD_BUSY);
    run_op("rem", REM, 32'hFFFFFFF9, 32'h2, mdx(32'hFFFFFFFF), MD_LAT, MD_BUSY);
    run_op("divu", DIVU, 32'd100, 32'd7, mdx(32'd14), MD_LAT, MD_BUSY);
    run_op("remu", REMU, 32'd100, 32'd7, mdx(32'd2), MD_LAT, MD_BUSY);
    run_op("divu_by0", DIVU, 32'h55, 32'h0, mdx(32'hFFFFFFFF), 1, 0);
    run_op("rem_by0", REM, 32'h1234, 32'h0, mdx(32'h00001234), 1, 0);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, mdx(32'h80000000), 1, 0);
    run_op("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);

    // Backpressure: result held while out_ready is low, then back-to-back issue.
    out_ready = 1'b0;
    exp_q.push_back(32'h3);
    in_valid = 1'b1; alu_op = ADD; a = 32'h1; b = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < 5; i++) begin
      check1("hold/out_valid", out_valid, 1'b1);
      check("hold/result", result, 32'h3);
      check1("hold/in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b1; alu_op = XOR; a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
    #1;
    check1("b2b/in_ready", in_ready, 1'b1);
    pop_check("b2b/first_result");
    exp_q.push_back(32'hFF00FF00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1("b2b/out_valid", out_valid, 1'b1);
    pop_check("b2b/second_result");
    @(posedge clk); #1;
    check1("b2b/drained", out_valid, 1'b0);

    // kill wins over a simultaneous acceptance.
    in_valid = 1'b1; kill = 1'b1; alu_op = ADD; a = 32'h9; b = 32'h9;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check1("kill_acc/out_valid", out_valid, 1'b0);
    check1("kill_acc/in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= out_valid; end
    check1("kill_acc/no_result", seen, 1'b0);

    // kill discards a completed but unconsumed result.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = ADD; a = 32'h4; b = 32'h4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1("kill_done/pre", out_valid, 1'b1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check1("kill_done/out_valid", out_valid, 1'b0);
    out_ready = 1'b1;

`ifdef ALU_ITER_MDU_EN
    // kill ten cycles into a divide.
    in_valid = 1'b1; alu_op = DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check1("kill_div/busy_before", busy, 1'b1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check1("kill_div/busy", busy, 1'b0);
    check1("kill_div/in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin seen |= out_valid; @(posedge clk); #1; end
    check1("kill_div/no_result", seen, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    run_op("pre_rst", ADD, 32'h11, 32'h22, 32'h33, 1, 0);
    in_valid = 1'b1; alu_op = MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check1("rst_mul/busy", busy, 1'b0);
    check1("rst_mul/out_valid", out_valid, 1'b0);
    check("rst_mul/result", result, 32'h0);
    check1("rst_mul/in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
`endif

    // Asynchronous reset while a result waits for the consumer.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = ADD; a = 32'h40; b = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_done/pre", result, 32'h42);
    #2 rst = 1'b1;
    #1;
    check1("rst_done/out_valid", out_valid, 1'b0);
    check("rst_done/result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_add", ADD, 32'h7, 32'h8, 32'hF, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
